// File: rtl/roteador_param_if.sv
// roteador_param_if: flit buses and per-port valid/ready
// for the five router ports.
interface roteador_param_if #(
    parameter int CW = 4,
    parameter int DW = 8
);
    localparam int FLIT = 2 * CW + DW;

    logic [5*FLIT-1:0] in_data;
    logic [4:0]        in_valid;
    logic [4:0]        in_ready;
    logic [5*FLIT-1:0] out_data;
    logic [4:0]        out_valid;
    logic [4:0]        out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/roteador_param.sv
// roteador_param: 5-port XY mesh router with per-input
// FIFOs and round-robin output arbiters.
module roteador_param #(
    parameter int CW    = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] coord_x,
    input  logic [CW-1:0] coord_y,
    roteador_param_if.slave bus
);
    localparam int FLIT = 2 * CW + DW;
    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = PW + 1;

    logic [FLIT-1:0] mem    [5][DEPTH];
    logic [PW-1:0]   wr_ptr [5];
    logic [PW-1:0]   rd_ptr [5];
    logic [CNTW-1:0] count  [5];
    logic [FLIT-1:0] head   [5];
    logic [CW-1:0]   xdst   [5];
    logic [CW-1:0]   ydst   [5];
    logic [4:0]      req    [5];
    logic [4:0]      gnt    [5];
    logic [2:0]      gidx   [5];
    logic [FLIT-1:0] gdata  [5];
    logic [2:0]      last   [5];
    logic [4:0]      load;
    logic [4:0]      push;
    logic [4:0]      pop;
    logic [4:0]      rdy;
    logic [4:0]      out_valid_q;
    logic [5*FLIT-1:0] out_data_q;

    assign bus.in_ready  = rdy;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign push = bus.in_valid & rdy;

    // Ready comes only from registered counts, so a full FIFO never pushes.
    always_comb begin
        for (int p = 0; p < 5; p++)
            rdy[p] = (count[p] != CNTW'(DEPTH));
    end

    // XY route of each FIFO head: one requested output per input.
    always_comb begin
        for (int p = 0; p < 5; p++) begin
            head[p] = mem[p][rd_ptr[p]];
            xdst[p] = head[p][FLIT-1 -: CW];
            ydst[p] = head[p][DW+CW-1 -: CW];
            req[p]  = '0;
            if (count[p] != '0) begin
                if (xdst[p] > coord_x)
                    req[p][3] = 1'b1;
                else if (xdst[p] < coord_x)
                    req[p][2] = 1'b1;
                else if (ydst[p] > coord_y)
                    req[p][1] = 1'b1;
                else if (ydst[p] < coord_y)
                    req[p][0] = 1'b1;
                else
                    req[p][4] = 1'b1;
            end
        end
    end

    // Round-robin search from last[o]+1; load only if the output frees up.
    always_comb begin
        logic found;
        int   idx;
        for (int o = 0; o < 5; o++) begin
            gnt[o]   = '0;
            gidx[o]  = last[o];
            gdata[o] = '0;
            found    = 1'b0;
            for (int k = 1; k <= 5; k++) begin
                idx = (int'(last[o]) + k) % 5;
                if (!found && req[idx][o]) begin
                    gnt[o][idx] = 1'b1;
                    gidx[o]     = 3'(idx);
                    gdata[o]    = head[idx];
                    found       = 1'b1;
                end
            end
            load[o] = found &&
                      (!out_valid_q[o] || bus.out_ready[o]);
        end
    end

    // An input pops when the output that granted it actually loads.
    always_comb begin
        for (int p = 0; p < 5; p++) begin
            pop[p] = 1'b0;
            for (int o = 0; o < 5; o++)
                pop[p] = pop[p] | (gnt[o][p] & load[o]);
        end
    end

    // FIFO storage; contents are don't-care until counted valid.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 5; p++)
            if (push[p])
                mem[p][wr_ptr[p]] <= bus.in_data[p*FLIT +: FLIT];
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < 5; p++) begin
                wr_ptr[p] <= '0;
                rd_ptr[p] <= '0;
                count[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < 5; p++) begin
                if (push[p])
                    wr_ptr[p] <= wr_ptr[p] + 1'b1;
                if (pop[p])
                    rd_ptr[p] <= rd_ptr[p] + 1'b1;
                count[p] <= count[p] + CNTW'(push[p])
                                     - CNTW'(pop[p]);
            end
        end
    end

    // Output registers and arbiter pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= '0;
            out_data_q  <= '0;
            for (int o = 0; o < 5; o++)
                last[o] <= 3'd4;
        end else begin
            for (int o = 0; o < 5; o++) begin
                if (load[o]) begin
                    out_data_q[o*FLIT +: FLIT] <= gdata[o];
                    out_valid_q[o] <= 1'b1;
                    last[o]        <= gidx[o];
                end else if (out_valid_q[o] && bus.out_ready[o]) begin
                    out_valid_q[o] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_roteador_param.sv
// tb_roteador_param: directed checks of routing, arbitration,
// backpressure and reset for a router at (1,1).
module tb_roteador_param;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    roteador_param_if #(.CW(4), .DW(8)) bus ();

    roteador_param #(.CW(4), .DW(8), .DEPTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .coord_x (4'd1),
        .coord_y (4'd1),
        .bus     (bus.slave)
    );

    function automatic logic [15:0] mk(input logic [3:0] x,
                                       input logic [3:0] y,
                                       input logic [7:0] p);
        return {x, y, p};
    endfunction

    function automatic logic [15:0] slice(input int o);
        return bus.out_data[o*16 +: 16];
    endfunction

    task automatic check(input string tag,
                         input logic [15:0] obs,
                         input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input int p, input logic [15:0] f,
                            input int o, input string tag);
        bus.in_data            = '0;
        bus.in_data[p*16 +: 16] = f;
        bus.in_valid           = 5'(5'b1 << p);
        step();
        bus.in_valid = '0;
        check({tag, " early"}, 16'(bus.out_valid), 16'h0);
        step();
        check({tag, " valid"}, 16'(bus.out_valid), 16'(5'b1 << o));
        check({tag, " data"}, slice(o), f);
        step();
        check({tag, " once"}, 16'(bus.out_valid), 16'h0);
        check({tag, " hold"}, slice(o), f);
    endtask

    initial begin
        bus.in_data   = '0;
        bus.in_valid  = '0;
        bus.out_ready = 5'h1f;

        #2 rst = 1'b1;
        #1;
        check("rst valid", 16'(bus.out_valid), 16'h0);
        check("rst data0", bus.out_data[15:0], 16'h0);
        check("rst data4", bus.out_data[79:64], 16'h0);
        check("rst ready", 16'(bus.in_ready), 16'h1f);
        step();
        step();
        rst = 1'b0;
        step();
        check("post rst ready", 16'(bus.in_ready), 16'h1f);

        send_one(4, 16'h31A5, 3, "core->dir");
        send_one(0, 16'h113C, 4, "cima->core");
        send_one(0, mk(1, 0, 8'h77), 0, "cima->cima");
        send_one(0, mk(1, 2, 8'h88), 1, "cima->baixo");
        send_one(3, mk(0, 1, 8'h99), 2, "dir->esq");

        bus.in_data[15:0]  = mk(2, 1, 8'h01);
        bus.in_data[31:16] = mk(2, 1, 8'h02);
        bus.in_valid       = 5'b00011;
        step();
        check("rr e1", 16'(bus.out_valid), 16'h0);
        step();
        bus.in_valid = '0;
        check("rr e2 v", 16'(bus.out_valid), 16'h8);
        check("rr e2 d", slice(3), mk(2, 1, 8'h01));
        step();
        check("rr e3 v", 16'(bus.out_valid), 16'h8);
        check("rr e3 d", slice(3), mk(2, 1, 8'h02));
        step();
        check("rr e4 d", slice(3), mk(2, 1, 8'h01));
        step();
        check("rr e5 d", slice(3), mk(2, 1, 8'h02));
        step();
        check("rr e6 v", 16'(bus.out_valid), 16'h0);

        bus.out_ready = 5'b10111;
        for (int i = 0; i < 6; i++) begin
            bus.in_data[79:64] = mk(3, 1, 8'(8'h10 + i));
            bus.in_valid       = 5'b10000;
            step();
            if (i == 4)
                check("bp full", 16'(bus.in_ready), 16'h0f);
        end
        bus.in_valid = '0;
        check("bp stall rdy", 16'(bus.in_ready), 16'h0f);
        check("bp stall v", 16'(bus.out_valid), 16'h8);
        check("bp stall d", slice(3), mk(3, 1, 8'h10));
        step();
        check("bp stable d", slice(3), mk(3, 1, 8'h10));
        bus.out_ready = 5'h1f;
        step();
        check("bp pop rdy", 16'(bus.in_ready), 16'h1f);
        check("bp f1", slice(3), mk(3, 1, 8'h11));
        for (int i = 2; i < 5; i++) begin
            step();
            check("bp order v", 16'(bus.out_valid), 16'h8);
            check("bp order d", slice(3), mk(3, 1, 8'(8'h10 + i)));
        end
        step();
        check("bp drained", 16'(bus.out_valid), 16'h0);

        bus.out_ready      = '0;
        bus.in_data[15:0]  = mk(1, 1, 8'h50);
        bus.in_data[31:16] = mk(1, 1, 8'h51);
        bus.in_data[47:32] = mk(1, 1, 8'h52);
        bus.in_valid       = 5'b00111;
        step();
        step();
        bus.in_valid = '0;
        step();
        check("mid setup", 16'(bus.out_valid), 16'h10);
        #2 rst = 1'b1;
        #1;
        check("mid rst v", 16'(bus.out_valid), 16'h0);
        check("mid rst d", bus.out_data[79:64], 16'h0);
        check("mid rst rdy", 16'(bus.in_ready), 16'h1f);
        #1 rst = 1'b0;
        bus.out_ready = 5'h1f;
        for (int i = 0; i < 4; i++) begin
            step();
            check("no stale", 16'(bus.out_valid), 16'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/roteador_param.md
ROTEADOR_PARAM -- requirements
Module: roteador_param

Interface
REQ-001 SHALL have parameter CW, default 4: coordinate field width.
REQ-002 SHALL have parameter DW, default 8: payload width.
REQ-003 SHALL have parameter DEPTH, default 4: per-input FIFO depth; power of two, >=2.
REQ-004 SHALL define FLIT = 2*CW+DW. Flit layout: [FLIT-1:DW+CW] x destination, [DW+CW-1:DW] y destination, [DW-1:0] payload.
REQ-005 SHALL index ports 0=cima, 1=baixo, 2=esquerda, 3=direita, 4=core; port p occupies slice [p*FLIT +: FLIT] of each bus.
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 coord_x, coord_y  input  CW each  this router's mesh position; static during operation.
REQ-009 in_data  input  5*FLIT  incoming flits.
REQ-010 in_valid  input  5  per-port flit present.
REQ-011 in_ready  output  5  per-port input FIFO can accept.
REQ-012 out_data  output  5*FLIT  outgoing flits.
REQ-013 out_valid  output  5  per-port output holds a flit.
REQ-014 out_ready  input  5  per-port downstream accepts.

Function
REQ-015 Each input p SHALL have a DEPTH-entry FIFO with a count register of width clog2(DEPTH)+1; in_ready[p] = (count != DEPTH); depends only on registered state.
REQ-016 A flit SHALL be written on a rising edge when in_valid[p] && in_ready[p]; a push into a full FIFO is impossible, so no flit is lost.
REQ-017 Simultaneous push and pop on one FIFO SHALL leave the count unchanged. Full FIFO: in_ready stays 0 that cycle regardless of pop. Empty FIFO: no bypass; the pushed flit becomes head on the next cycle.
REQ-018 The head flit of each non-empty FIFO SHALL request exactly one output, XY order, first match wins:
- x_dst > coord_x -> direita
- x_dst < coord_x -> esquerda
- y_dst > coord_y -> baixo
- y_dst < coord_y -> cima
- else -> core
REQ-019 Each output o SHALL have a round-robin arbiter with 3-bit pointer last[o]. It searches inputs last[o]+1, last[o]+2, ... modulo 5 and grants the first requester.
REQ-020 Output register o SHALL be loadable when out_valid[o]==0, or when out_valid[o] && out_ready[o] in the same cycle.
REQ-021 On a load, the granted FIFO SHALL pop, out_data slice o takes the head flit, out_valid[o] is set, and last[o] takes the granted index. Without a grant, last[o] SHALL hold.
REQ-022 When out_valid[o] && out_ready[o] and no new grant, out_valid[o] SHALL clear; out_data slice o keeps its last value.
REQ-023 While out_valid[o] && !out_ready[o], out_data slice o and out_valid[o] SHALL stay stable.
REQ-024 Each input SHALL be granted by at most one output per cycle, guaranteed by REQ-018.
REQ-025 Latency SHALL be 2 cycles with no contention or backpressure: flit accepted at edge t, out_valid high after edge t+1.
REQ-026 Flits from one input to one output SHALL leave in arrival order.
REQ-027 Throughput SHALL be one flit per output per cycle under continuous out_ready.
REQ-028 Flits SHALL pass unmodified; coordinate comparisons SHALL be unsigned, CW bits.

Reset
REQ-029 While rst is high, regardless of clk:
- all FIFO counts and read/write pointers = 0
- out_valid = 0 and out_data = 0
- every last[o] = 4, so input 0 has first priority
REQ-030 in_ready SHALL read 5'b11111 during and after reset.
REQ-031 Reset mid-operation SHALL discard all buffered and output flits with no partial output.

Verification (CW=4, DW=8, coord_x=1, coord_y=1)
REQ-032 Assert rst mid-cycle -> out_valid=0, out_data=0 immediately; in_ready=5'b11111.
REQ-033 Core injects x=3, y=1, payload 0xA5 at edge t, out_ready all 1 -> out_valid[3]=1 after edge t+1, slice 3 = 16'h31A5, one cycle only.
REQ-034 Cima injects x=1, y=1, payload 0x3C -> out_valid[4] with 16'h113C after 2 edges; a flit with y=0 exits cima, a flit with y=2 exits baixo.
REQ-035 Cima (0x01) and baixo (0x02) both target x=2 on one edge, repeated for 2 edges -> direita emits cima, baixo, cima, baixo on consecutive cycles.
REQ-036 out_ready[3]=0, core pushes 6 flits to x=3 -> 5 accepted (1 in output register, 4 in FIFO), then in_ready[4]=0; raise out_ready[3] -> 5 flits emitted in order, in_ready[4] rises after the first pop.
REQ-037 Flits buffered in 3 FIFOs, pulse rst -> all outputs clear; no stale flit emitted afterwards.
